// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display scheduler: hex glyphs,
// scheduler states and the round-robin pick helper.
package seg_pkg;

  // All segments dark on the active-low pins.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high glyphs, bit6..0 = a..g, indexed by hex digit value.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Largest requester count the pick helper handles.
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First valid requester at or after ptr, wrapping modulo n.
  // Scanning offsets from high to low lets the smallest offset win.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0] ptr,
                                    input int n);
    pick_t p;
    int    c;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        c = int'(ptr) + k;
        if (c >= n) c = c - n;
        if (valid[c[2:0]]) begin
          p.found = 1'b1;
          p.idx   = c[2:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/seg_hex_encode.sv
// Combinational hex digit to active-high seven-segment glyph.
module seg_hex_encode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg_display_sched.sv
// Round-robin scheduler sharing the two-digit seven-segment display among
// NUM_REQ byte producers. Each accepted byte is held for HOLD_CYCLES, with an
// optional dark gap of BLANK_CYCLES when another message is already waiting.
module seg_display_sched
  import seg_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int HOLD_CYCLES  = 12_500_000,
  parameter int BLANK_CYCLES = 1_250_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       clear,
  output logic [6:0]                 disp1,
  output logic [6:0]                 disp2,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_src
);

  localparam int SW         = $clog2(NUM_REQ);
  localparam int MAX_CYC    = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYC + 1);
  localparam int HOLD_LAST  = HOLD_CYCLES - 1;
  // With no gap the BLANK state is never entered, so this value is never compared.
  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [SW-1:0]   ptr_reg;
  logic [SW-1:0]   cur_src_reg;
  logic [6:0]      disp1_reg, disp2_reg;

  logic [7:0]      req_byte [NUM_REQ];
  logic [7:0]      sel_byte;
  pick_t           pick;
  logic            pick_unused;
  logic [SW-1:0]   gidx;
  logic            accept;
  logic [6:0]      glyph_lo, glyph_hi;

  // Split the flat data bus into one byte per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  assign pick        = rr_pick(8'(req_valid), 3'(ptr_reg), NUM_REQ);
  assign pick_unused = ^pick;
  assign gidx        = pick.idx[SW-1:0];
  assign sel_byte    = req_byte[gidx];

  // Grant only in IDLE, never while clearing or held in reset.
  assign accept = rst_n && !clear && (state_reg == IDLE) && pick.found;

  seg_hex_encode u_enc_lo (.nibble(sel_byte[3:0]), .seg(glyph_lo));
  seg_hex_encode u_enc_hi (.nibble(sel_byte[7:4]), .seg(glyph_hi));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and dwell counter; the counter restarts on every state entry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SHOW;
      SHOW:    if (cnt_reg == CW'(HOLD_LAST))
                 state_next = ((|req_valid) && (BLANK_CYCLES > 0)) ? BLANK : IDLE;
      BLANK:   if (cnt_reg == CW'(BLANK_LAST)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
    cnt_next = '0;
    if ((state_next == state_reg) && (state_reg != IDLE)) cnt_next = cnt_reg + 1'b1;
  end

  // Datapath: counter, round-robin pointer, source index and segment latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      ptr_reg     <= '0;
      cur_src_reg <= '0;
      disp1_reg   <= SEG_OFF;
      disp2_reg   <= SEG_OFF;
    end else begin
      cnt_reg <= cnt_next;
      if (clear) begin
        disp1_reg <= SEG_OFF;
        disp2_reg <= SEG_OFF;
      end else if (accept) begin
        disp1_reg   <= ~glyph_lo;
        disp2_reg   <= ~glyph_hi;
        cur_src_reg <= gidx;
        ptr_reg     <= (gidx == SW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      end else if ((state_reg == SHOW) && (state_next == BLANK)) begin
        disp1_reg <= SEG_OFF;
        disp2_reg <= SEG_OFF;
      end
    end
  end

  // Outputs: one-hot ready strobe and busy flag.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gidx] = 1'b1;
    busy = (state_reg != IDLE);
  end

  assign disp1   = disp1_reg;
  assign disp2   = disp2_reg;
  assign cur_src = cur_src_reg;

endmodule
